ed_window_buffer: RTL and testbench

Parametrised 3x3 neighbourhood generator for the edge detection pipeline. It takes a raster stream of DATA_W-bit pixels with a valid qualifier and a start-of-frame marker. It holds two full lines in column-indexed line memories and presents a registered 3x3 window, with centre coordinates and a border flag, to the downstream Sobel/threshold stage. It replaces chains of fixed 320-deep 12-bit shift buffers with one block that is configurable in width, line length and frame height, and tolerates gaps in the input stream.

---
 rtl/ed_window_buffer_if.sv | 26 ++
 rtl/ed_window_buffer.sv | 114 +++++++++++
 tb/tb_ed_window_buffer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/ed_window_buffer_if.sv
// Pixel-stream and 3x3 window bundle for ed_window_buffer.
// The master side drives pixels and the slave side (the window buffer) returns windows.
interface ed_window_buffer_if #(
  parameter int DATA_W = 12,
  parameter int XW     = 9,
  parameter int YW     = 8
);
  logic                  in_valid;
  logic                  sof;
  logic [DATA_W-1:0]     data_in;
  logic                  win_valid;
  logic [9*DATA_W-1:0]   win;
  logic [XW-1:0]         centre_x;
  logic [YW-1:0]         centre_y;
  logic                  border;

  modport master (
    output in_valid, sof, data_in,
    input  win_valid, win, centre_x, centre_y, border
  );

  modport slave (
    input  in_valid, sof, data_in,
    output win_valid, win, centre_x, centre_y, border
  );
endinterface

// File: rtl/ed_window_buffer.sv
// Raster-to-3x3 window generator using two column-indexed line memories.
// Optional macro ED_WIN_BORDER_ZERO_EN forces out-of-frame taps to zero at the top/left borders.
module ed_window_buffer #(
  parameter int DATA_W = 12,
  parameter int H_SIZE = 320,
  parameter int V_SIZE = 240
) (
  input  logic              clk,
  input  logic              reset_n,
  ed_window_buffer_if.slave bus
);
  localparam int XW = $clog2(H_SIZE);
  localparam int YW = $clog2(V_SIZE);
  localparam logic [XW-1:0] X_LAST = XW'(H_SIZE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_SIZE - 1);

  logic [XW-1:0]              r_x, w_x, w_x_next, w_cx, r_cx;
  logic [YW-1:0]              r_y, w_y, w_y_next, w_cy, r_cy;
  logic [DATA_W-1:0]          r_mem_a [H_SIZE];
  logic [DATA_W-1:0]          r_mem_b [H_SIZE];
  logic [2:0][DATA_W-1:0]     r_col1, r_col2, w_col_new;
  logic [9*DATA_W-1:0]        w_win_next, r_win;
  logic                       w_emit, r_win_valid, r_border;

  // r_x/r_y hold the position of the next pixel; sof overrides it to (0,0).
  always_comb begin
    w_x      = bus.sof ? '0 : r_x;
    w_y      = bus.sof ? '0 : r_y;
    w_x_next = w_x + XW'(1);
    w_y_next = w_y;
    if (w_x == X_LAST) begin
      w_x_next = '0;
      w_y_next = (w_y == Y_LAST) ? '0 : w_y + YW'(1);
    end
    w_emit = bus.in_valid && (w_x != '0) && (w_y != '0);
    w_cx   = w_x - XW'(1);
    w_cy   = w_y - YW'(1);
  end

  // Row 0 is two lines up (B), row 1 one line up (A), row 2 the incoming pixel.
  assign w_col_new[0] = r_mem_b[w_x];
  assign w_col_new[1] = r_mem_a[w_x];
  assign w_col_new[2] = bus.data_in;

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_tap
      localparam int R = gi / 3;
      localparam int C = gi % 3;
      logic [DATA_W-1:0] w_raw;
      if (C == 0) begin : g_c0
        assign w_raw = r_col1[R];
      end else if (C == 1) begin : g_c1
        assign w_raw = r_col2[R];
      end else begin : g_c2
        assign w_raw = w_col_new[R];
      end
`ifdef ED_WIN_BORDER_ZERO_EN
      logic w_kill;
      assign w_kill = ((R == 0) && (w_cy == '0)) || ((C == 0) && (w_cx == '0));
      assign w_win_next[gi*DATA_W +: DATA_W] = w_kill ? '0 : w_raw;
`else
      assign w_win_next[gi*DATA_W +: DATA_W] = w_raw;
`endif
    end
  endgenerate

  // Line memories: no reset, read-before-write at the same column.
  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      r_mem_a[w_x] <= bus.data_in;
      r_mem_b[w_x] <= r_mem_a[w_x];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x    <= '0;
      r_y    <= '0;
      r_col1 <= '0;
      r_col2 <= '0;
    end else if (bus.in_valid) begin
      r_x    <= w_x_next;
      r_y    <= w_y_next;
      r_col1 <= r_col2;
      r_col2 <= w_col_new;
    end
  end

  // Window outputs only change on emission so they stay stable between pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_win_valid <= 1'b0;
      r_win       <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_border    <= 1'b0;
    end else begin
      r_win_valid <= w_emit;
      if (w_emit) begin
        r_win    <= w_win_next;
        r_cx     <= w_cx;
        r_cy     <= w_cy;
        r_border <= (w_cx == '0) || (w_cy == '0);
      end
    end
  end

  assign bus.win_valid = r_win_valid;
  assign bus.win       = r_win;
  assign bus.centre_x  = r_cx;
  assign bus.centre_y  = r_cy;
  assign bus.border    = r_border;
endmodule

// File: tb/tb_ed_window_buffer.sv
// Self-checking bench for ed_window_buffer on a 4x3 frame with 12-bit pixels.
// Expected windows come from the accepted-pixel stream: tap (r,c) is the pixel accepted (2-c)+(2-r)*H earlier.
module tb_ed_window_buffer;
  localparam int DW = 12;
  localparam int H  = 4;
  localparam int V  = 3;
  localparam int XW = $clog2(H);
  localparam int YW = $clog2(V);
`ifdef ED_WIN_BORDER_ZERO_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  typedef struct {
    logic          vld;
    logic          sof;
    logic [DW-1:0] data;
    logic          emit;
    int            cx;
    int            cy;
  } vec_t;

  typedef struct {
    int              cx;
    int              cy;
    logic            border;
    logic [9*DW-1:0] win;
    logic [9*DW-1:0] mask;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ed_window_buffer_if #(.DATA_W(DW), .XW(XW), .YW(YW)) bus ();

  ed_window_buffer #(.DATA_W(DW), .H_SIZE(H), .V_SIZE(V)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  vec_t            tbl[$];
  exp_t            sbq[$];
  logic [DW-1:0]   stream[$];
  logic [9*DW-1:0] cap_win[$];
  exp_t            last;
  int              n_checks = 0;
  int              n_pass = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp,
                     input logic [127:0] mask);
    n_checks++;
    if ((act & mask) === (exp & mask)) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act & mask, exp & mask);
  endtask

  // Pixel p of a raster run starting at (0,0); data = base + y*16 + x.
  function automatic vec_t mkpix(input int p, input int base, input bit sof_first);
    vec_t v;
    int x, y;
    x      = p % H;
    y      = (p / H) % V;
    v.vld  = 1'b1;
    v.sof  = sof_first && (p == 0);
    v.data = DW'(base + y * 16 + x);
    v.emit = (x >= 1) && (y >= 1);
    v.cx   = x - 1;
    v.cy   = y - 1;
    return v;
  endfunction

  function automatic vec_t idle();
    vec_t v;
    v.vld = 1'b0; v.sof = 1'b0; v.data = '0; v.emit = 1'b0; v.cx = 0; v.cy = 0;
    return v;
  endfunction

  function automatic exp_t build_exp(input vec_t v);
    exp_t e;
    int n, idx, r, c;
    n        = stream.size() - 1;
    e.cx     = v.cx;
    e.cy     = v.cy;
    e.border = (v.cx == 0) || (v.cy == 0);
    e.win    = '0;
    e.mask   = '0;
    for (int k = 0; k < 9; k++) begin
      r   = k / 3;
      c   = k % 3;
      idx = n - (2 - c) - (2 - r) * H;
      if (ZERO_EN && ((r == 0 && v.cy == 0) || (c == 0 && v.cx == 0))) begin
        e.mask[k*DW +: DW] = '1;
      end else if (idx >= 0) begin
        e.win[k*DW +: DW]  = stream[idx];
        e.mask[k*DW +: DW] = '1;
      end
    end
    return e;
  endfunction

  task automatic apply(input vec_t v);
    exp_t e;
    logic exp_emit;
    bus.in_valid = v.vld;
    bus.sof      = v.sof;
    bus.data_in  = v.data;
    exp_emit     = v.vld && v.emit;
    if (v.vld) begin
      if (v.sof) stream.delete();
      stream.push_back(v.data);
    end
    if (exp_emit) sbq.push_back(build_exp(v));
    @(posedge clk);
    #1;
    chk("win_valid", 128'(bus.win_valid), 128'(exp_emit), 128'(1));
    if (bus.win_valid) begin
      cap_win.push_back(bus.win);
      if (sbq.size() == 0) begin
        chk("sb_has_entry", 128'(0), 128'(1), 128'(1));
      end else begin
        e = sbq.pop_front();
        chk("centre_x", 128'(bus.centre_x), 128'(e.cx), '1);
        chk("centre_y", 128'(bus.centre_y), 128'(e.cy), '1);
        chk("border",   128'(bus.border),   128'(e.border), '1);
        chk("win",      128'(bus.win),      128'(e.win), 128'(e.mask));
        last = e;
      end
    end else begin
      if (exp_emit) e = sbq.pop_front();
      chk("hold_centre_x", 128'(bus.centre_x), 128'(last.cx), '1);
      chk("hold_centre_y", 128'(bus.centre_y), 128'(last.cy), '1);
      chk("hold_border",   128'(bus.border),   128'(last.border), '1);
      chk("hold_win",      128'(bus.win),      128'(last.win), 128'(last.mask));
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_win_valid"}, 128'(bus.win_valid), 128'(0), '1);
    chk({tag, "_win"},       128'(bus.win),       128'(0), '1);
    chk({tag, "_centre_x"},  128'(bus.centre_x),  128'(0), '1);
    chk({tag, "_centre_y"},  128'(bus.centre_y),  128'(0), '1);
    chk({tag, "_border"},    128'(bus.border),    128'(0), '1);
  endtask

  initial begin
    logic [9*DW-1:0] w;
    logic [9*DW-1:0] full_c11;

    // Frame A continuous; frame with gaps; two back-to-back frames; sof at (2,1).
    for (int p = 0; p < 12; p++) tbl.push_back(mkpix(p, 0, 1'b1));
    for (int p = 0; p < 12; p++) begin
      tbl.push_back(mkpix(p, 0, 1'b1));
      tbl.push_back(idle());
    end
    for (int p = 0; p < 24; p++) tbl.push_back(mkpix(p, 0, 1'b1));
    for (int p = 0; p < 6; p++)  tbl.push_back(mkpix(p, 'h100, 1'b1));
    for (int p = 0; p < 12; p++) tbl.push_back(mkpix(p, 'h180, 1'b1));

    last.cx = 0; last.cy = 0; last.border = 1'b0; last.win = '0; last.mask = '1;
    bus.in_valid = 1'b0;
    bus.sof      = 1'b0;
    bus.data_in  = '0;
    #2;
    chk_zero_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
    apply(idle());

    chk("pulse_count_tables", 128'(cap_win.size()), 128'(31), '1);
    if (cap_win.size() >= 5) begin
      w = cap_win[0];
      chk("c00_tap11", 128'(w[4*DW +: DW]), 128'(12'h000), '1);
      chk("c00_tap22", 128'(w[8*DW +: DW]), 128'(12'h011), '1);
      w = cap_win[3];
      chk("c01_tap10", 128'(w[3*DW +: DW]), ZERO_EN ? 128'(0) : 128'(12'h003), '1);
      chk("c01_tap20", 128'(w[6*DW +: DW]), ZERO_EN ? 128'(0) : 128'(12'h013), '1);
      full_c11 = {12'h022, 12'h021, 12'h020, 12'h012, 12'h011, 12'h010,
                  12'h002, 12'h001, 12'h000};
      chk("c11_window", 128'(cap_win[4]), 128'(full_c11), '1);
    end

    // Mid-line asynchronous reset, then a frame with no sof.
    for (int p = 0; p < 6; p++) apply(mkpix(p, 'h300, 1'b1));
    bus.in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero_outputs("async_reset");
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    last.cx = 0; last.cy = 0; last.border = 1'b0; last.win = '0; last.mask = '1;
    stream.delete();
    for (int p = 0; p < 12; p++) apply(mkpix(p, 'h400, 1'b0));
    apply(idle());

    chk("pulse_count_total", 128'(cap_win.size()), 128'(38), '1);
    chk("scoreboard_empty", 128'(sbq.size()), 128'(0), '1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
